// File: rtl/config_frame_pkg.sv
// Shared types and field positions for the configuration frame writer.
package config_frame_pkg;

  typedef enum logic [2:0] {IDLE, HEADER, DATA, STROBE, HOLD} stateT;

  localparam int HdrDesyncBit = 31;
  localparam int HdrColMsb    = 30;
  localparam int HdrColLsb    = 23;
  localparam int HdrIdxMsb    = 20;
  localparam int HdrIdxLsb    = 16;
  localparam int IdxW         = HdrIdxMsb - HdrIdxLsb + 1;

  localparam logic [31:0] DefaultSyncWord = 32'hFAB0_FAB1;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_strobe_gen.sv
// Drives one FrameStrobe line high for StrobeCycles clocks after a start pulse.
module frame_strobe_gen
  import config_frame_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int StrobeCycles    = 2
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [IdxW-1:0]            index,
  input  logic                       start,
  output logic [MaxFramesPerCol-1:0] frameStrobe,
  output logic                       done
);

  localparam int CntW = cntWidth(StrobeCycles);

  logic [CntW-1:0] cnt;
  logic            active;

  // done marks the final high cycle so the owner can leave STROBE on the same edge the line drops.
  assign done = active && (cnt == '0);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      active      <= 1'b0;
      cnt         <= '0;
      frameStrobe <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= CntW'(StrobeCycles - 1);
      for (int i = 0; i < MaxFramesPerCol; i++) begin
        frameStrobe[i] <= (int'(index) == i);
      end
    end else if (active) begin
      if (cnt == '0) begin
        active      <= 1'b0;
        frameStrobe <= '0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/config_frame_writer.sv
// Configuration-port frame writer for one tile column: finds sync, parses headers,
// assembles row words into FrameData and pulses the addressed FrameStrobe line.
module config_frame_writer
  import config_frame_pkg::*;
#(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 20,
  parameter int          NumRows         = 2,
  parameter logic [7:0]  ColumnId        = 8'd0,
  parameter int          StrobeCycles    = 2,
  parameter logic [31:0] SyncWord        = DefaultSyncWord
) (
  input  logic                                CLK,
  input  logic                                resetn,
  input  logic [31:0]                         s_data,
  input  logic                                s_valid,
  output logic                                s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
  output logic [MaxFramesPerCol-1:0]          FrameStrobe,
  output logic                                synced,
  output logic                                busy,
  output logic                                frame_err,
  output logic [15:0]                         frames_written
);

  localparam int RowCntW = cntWidth(NumRows);

  stateT              state;
  logic [RowCntW-1:0] rowCnt;
  logic [IdxW-1:0]    frameIdx;
  logic               frameMatch;
  logic               xfer;
  logic               lastRow;
  logic               idxOk;
  logic               strobeStart;
  logic               strobeDone;

  assign xfer        = s_valid && s_ready;
  assign lastRow     = (rowCnt == RowCntW'(NumRows - 1));
  assign idxOk       = (int'(frameIdx) < MaxFramesPerCol);
  assign strobeStart = (state == DATA) && xfer && lastRow && frameMatch && idxOk;
  assign busy        = !((state == IDLE) || (state == HEADER));

  frame_strobe_gen #(
    .MaxFramesPerCol(MaxFramesPerCol),
    .StrobeCycles   (StrobeCycles)
  ) strobeGen (
    .CLK        (CLK),
    .resetn     (resetn),
    .index      (frameIdx),
    .start      (strobeStart),
    .frameStrobe(FrameStrobe),
    .done       (strobeDone)
  );

  // s_ready is registered so it reads 0 while reset is held and rises on the first clock after.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      s_ready        <= 1'b0;
      synced         <= 1'b0;
      frame_err      <= 1'b0;
      frames_written <= '0;
      rowCnt         <= '0;
      frameIdx       <= '0;
      frameMatch     <= 1'b0;
      FrameData      <= '0;
    end else begin
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (xfer && (s_data == SyncWord)) begin
            state  <= HEADER;
            synced <= 1'b1;
          end
        end
        HEADER: begin
          s_ready <= 1'b1;
          if (xfer) begin
            if (s_data[HdrDesyncBit]) begin
              state  <= IDLE;
              synced <= 1'b0;
            end else begin
              state      <= DATA;
              rowCnt     <= '0;
              frameIdx   <= s_data[HdrIdxMsb:HdrIdxLsb];
              frameMatch <= (s_data[HdrColMsb:HdrColLsb] == ColumnId);
            end
          end
        end
        DATA: begin
          s_ready <= 1'b1;
          if (xfer) begin
            if (frameMatch) begin
              for (int r = 0; r < NumRows; r++) begin
                if (rowCnt == RowCntW'(r)) begin
                  FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                end
              end
            end
            if (lastRow) begin
              rowCnt <= '0;
              if (frameMatch && idxOk) begin
                state          <= STROBE;
                s_ready        <= 1'b0;
                frames_written <= frames_written + 16'd1;
              end else begin
                state <= HEADER;
                if (frameMatch) begin
                  frame_err <= 1'b1;
                end
              end
            end else begin
              rowCnt <= rowCnt + 1'b1;
            end
          end
        end
        STROBE: begin
          s_ready <= 1'b0;
          if (strobeDone) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          s_ready <= 1'b1;
          state   <= HEADER;
        end
        default: begin
          s_ready <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
